// File: rtl/tamagotchi_btn_cond.sv
// Pushbutton front end for tamagotchi_fsm: synchronises and debounces the six raw buttons,
// emits single-cycle press pulses for the care buttons and turns long holds on reset/test
// into a reset request pulse and a test-mode toggle. Every output is registered.
module tamagotchi_btn_cond #(
  parameter int unsigned DB_CYCLES   = 500_000,
  parameter int unsigned LONG_CYCLES = 250_000_000,
  parameter bit          ACTIVE_LOW  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_salud_raw,
  input  logic       btn_energia_raw,
  input  logic       btn_hambre_raw,
  input  logic       btn_diversion_raw,
  input  logic       btn_reset_raw,
  input  logic       btn_test_raw,
  output logic       press_salud,
  output logic       press_energia,
  output logic       press_hambre,
  output logic       press_diversion,
  output logic       reset_req,
  output logic       test_mode,
  output logic [5:0] btn_level
);

  localparam int unsigned NumBtn = 6;
  localparam int unsigned CntW   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int unsigned HoldW  = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;

  localparam logic [CntW-1:0]  DbLast   = CntW'(DB_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_CYCLES - 1);
  // Hold count one below saturation: the increment into HoldLast is the long-press event.
  localparam logic [HoldW-1:0] HoldFire = HoldW'(LONG_CYCLES - 2);

  // Bit order {test, reset, diversion, hambre, energia, salud}.
  logic [NumBtn-1:0] raw_vec;
  logic [NumBtn-1:0] s1_q, s2_q, stable_q, prev_q;
  logic [CntW-1:0]   cnt_q [NumBtn];
  logic [3:0]        press_q;
  logic [HoldW-1:0]  hold_q [2];
  logic [1:0]        long_fire;
  logic              reset_req_q;
  logic              test_mode_q;

  assign raw_vec = {btn_test_raw, btn_reset_raw, btn_diversion_raw,
                    btn_hambre_raw, btn_energia_raw, btn_salud_raw} ^ {NumBtn{ACTIVE_LOW}};

  // Index 0 = reset button, index 1 = test button.
  assign long_fire[0] = stable_q[4] && (hold_q[0] == HoldFire);
  assign long_fire[1] = stable_q[5] && (hold_q[1] == HoldFire);

  // Two-flop synchroniser and per-button debounce counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      stable_q <= '0;
      for (int i = 0; i < NumBtn; i++) cnt_q[i] <= '0;
    end else begin
      s1_q <= raw_vec;
      s2_q <= s1_q;
      for (int i = 0; i < NumBtn; i++) begin
        if (s2_q[i] == stable_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == DbLast) begin
          stable_q[i] <= s2_q[i];
          cnt_q[i]    <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Rising-edge press pulses, saturating hold counters and the test-mode level.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q      <= '0;
      press_q     <= '0;
      hold_q[0]   <= '0;
      hold_q[1]   <= '0;
      reset_req_q <= 1'b0;
      test_mode_q <= 1'b0;
    end else begin
      prev_q  <= stable_q;
      press_q <= stable_q[3:0] & ~prev_q[3:0];
      for (int j = 0; j < 2; j++) begin
        if (!stable_q[4+j]) begin
          hold_q[j] <= '0;
        end else if (hold_q[j] != HoldLast) begin
          hold_q[j] <= hold_q[j] + 1'b1;
        end
      end
      reset_req_q <= long_fire[0];
      // A game reset wins over a simultaneous test toggle.
      if (long_fire[0]) begin
        test_mode_q <= 1'b0;
      end else if (long_fire[1]) begin
        test_mode_q <= ~test_mode_q;
      end
    end
  end

  assign press_salud     = press_q[0];
  assign press_energia   = press_q[1];
  assign press_hambre    = press_q[2];
  assign press_diversion = press_q[3];
  assign reset_req       = reset_req_q;
  assign test_mode       = test_mode_q;
  assign btn_level       = stable_q;

endmodule

// File: tb/tb_tamagotchi_btn_cond.sv
// Bench for tamagotchi_btn_cond: directed scenarios plus random button activity, every
// cycle compared against a history-window reference model.
module tb_tamagotchi_btn_cond;

  localparam int DB   = 4;
  localparam int LONG = 16;
  localparam int MAXC = 4096;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] raw = '0;  // {test, reset, diversion, hambre, energia, salud}
  logic       press_salud, press_energia, press_hambre, press_diversion;
  logic       reset_req, test_mode;
  logic [5:0] btn_level;

  always #5 clk = ~clk;

  tamagotchi_btn_cond #(
    .DB_CYCLES  (DB),
    .LONG_CYCLES(LONG),
    .ACTIVE_LOW (1'b0)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .btn_salud_raw    (raw[0]),
    .btn_energia_raw  (raw[1]),
    .btn_hambre_raw   (raw[2]),
    .btn_diversion_raw(raw[3]),
    .btn_reset_raw    (raw[4]),
    .btn_test_raw     (raw[5]),
    .press_salud      (press_salud),
    .press_energia    (press_energia),
    .press_hambre     (press_hambre),
    .press_diversion  (press_diversion),
    .reset_req        (reset_req),
    .test_mode        (test_mode),
    .btn_level        (btn_level)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: effective synchronised sample per edge and debounced level per edge.
  bit   samp [6][MAXC];
  bit   stab [6][MAXC];
  int   t = 0;
  bit [3:0] press_m;
  bit   req_m, tm_m;

  function automatic bit sget(int i, int idx);
    return (idx < 0) ? 1'b0 : samp[i][idx];
  endfunction

  function automatic bit stget(int i, int idx);
    return (idx < 0) ? 1'b0 : stab[i][idx];
  endfunction

  // Length of the run of debounced-high edges ending at idx.
  function automatic int run_len(int i, int idx);
    int n = 0;
    while (n <= LONG + 1 && stget(i, idx - n)) n++;
    return n;
  endfunction

  task automatic model_edge();
    bit fire_r, fire_t, v, all;
    for (int i = 0; i < 6; i++) begin
      if (rst) begin
        // Reset clears both synchroniser stages: the last two samples become 0.
        samp[i][t] = 1'b0;
        if (t > 0) samp[i][t-1] = 1'b0;
        stab[i][t] = 1'b0;
      end else begin
        samp[i][t] = raw[i];
        // Level flips once DB consecutive synchronised samples all disagree with it.
        v   = sget(i, t - 2);
        all = 1'b1;
        for (int k = 0; k < DB; k++) if (sget(i, t - 2 - k) != v) all = 1'b0;
        stab[i][t] = (all && v != stget(i, t - 1)) ? v : stget(i, t - 1);
      end
    end
    if (rst) begin
      press_m = '0;
      req_m   = 1'b0;
      tm_m    = 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) press_m[i] = stget(i, t - 1) && !stget(i, t - 2);
      fire_r = (run_len(4, t - 1) == LONG - 1);
      fire_t = (run_len(5, t - 1) == LONG - 1);
      req_m  = fire_r;
      if (fire_r) tm_m = 1'b0;
      else if (fire_t) tm_m = ~tm_m;
    end
  endtask

  // Observation bookkeeping for the directed scenarios.
  int  seen_press [4];
  int  seen_req, tm_toggles, both_13, level2_high, step_no, first_salud;
  bit  tm_at_req, prev_tm;

  task automatic clear_obs();
    for (int i = 0; i < 4; i++) seen_press[i] = 0;
    seen_req    = 0;
    tm_toggles  = 0;
    both_13     = 0;
    level2_high = 0;
    step_no     = 0;
    first_salud = -1;
    tm_at_req   = 1'b1;
  endtask

  task automatic step(input int n);
    logic [3:0] p;
    repeat (n) begin
      @(posedge clk);
      if (t >= MAXC) begin
        $display("FAIL model_history: got %0d expected <%0d", t, MAXC);
        $fatal(1);
      end
      model_edge();
      #1;
      p = {press_diversion, press_hambre, press_energia, press_salud};
      check_eq("press", {28'd0, p}, {28'd0, press_m});
      check_eq("reset_req", {31'd0, reset_req}, {31'd0, req_m});
      check_eq("test_mode", {31'd0, test_mode}, {31'd0, tm_m});
      check_eq("btn_level", {26'd0, btn_level}, {26'd0, stab[5][t], stab[4][t], stab[3][t],
                                                 stab[2][t], stab[1][t], stab[0][t]});
      step_no++;
      for (int i = 0; i < 4; i++) if (p[i]) seen_press[i]++;
      if (p[0] && first_salud < 0) first_salud = step_no;
      if (p[1] && p[3]) both_13++;
      if (btn_level[2]) level2_high++;
      if (reset_req) begin
        seen_req++;
        tm_at_req = test_mode;
      end
      if (test_mode != prev_tm) tm_toggles++;
      prev_tm = test_mode;
      t++;
    end
  endtask

  task automatic test_hold(input int len);
    raw[5] = 1'b1;
    step(len);
    raw[5] = 1'b0;
    step(12);
  endtask

  initial begin
    prev_tm = 1'b0;
    clear_obs();
    // Reset state
    step(3);
    check_eq("reset_outputs", {21'd0, press_salud, press_energia, press_hambre, press_diversion,
                               reset_req, test_mode, btn_level}, 32'd0);
    rst = 1'b0;
    step(2);

    // 1: clean salud press; latency counted with the first sampling edge as edge 1
    clear_obs();
    raw[0] = 1'b1;
    step(20);
    raw[0] = 1'b0;
    step(12);
    check_eq("s1_count", seen_press[0], 1);
    check_eq("s1_latency", first_salud, 7);

    // 2: short glitch, then a bouncy hold
    clear_obs();
    raw[2] = 1'b1;
    step(3);
    raw[2] = 1'b0;
    step(12);
    check_eq("s2_glitch_press", seen_press[2], 0);
    check_eq("s2_glitch_level", level2_high, 0);
    clear_obs();
    for (int c = 0; c < 20; c++) begin
      raw[2] = !(c == 6 || c == 11 || c == 15);
      step(1);
    end
    raw[2] = 1'b0;
    step(12);
    check_eq("s2_bounce_count", seen_press[2], 1);

    // 3: test long press toggles, short hold does not
    clear_obs();
    test_hold(30);
    check_eq("s3_first_toggles", tm_toggles, 1);
    check_eq("s3_first_mode", test_mode, 1);
    clear_obs();
    test_hold(30);
    check_eq("s3_second_mode", test_mode, 0);
    clear_obs();
    test_hold(8);
    check_eq("s3_short_toggles", tm_toggles, 0);

    // 4: reset long press clears test mode in the same cycle as the request
    test_hold(30);
    check_eq("s4_pre_mode", test_mode, 1);
    clear_obs();
    raw[4] = 1'b1;
    step(25);
    raw[4] = 1'b0;
    step(12);
    check_eq("s4_req_count", seen_req, 1);
    check_eq("s4_mode_at_req", tm_at_req, 0);

    // 5: simultaneous energia and diversion
    clear_obs();
    raw[1] = 1'b1;
    raw[3] = 1'b1;
    step(15);
    raw[1] = 1'b0;
    raw[3] = 1'b0;
    step(12);
    check_eq("s5_energia", seen_press[1], 1);
    check_eq("s5_diversion", seen_press[3], 1);
    check_eq("s5_same_cycle", both_13, 1);

    // 6: reset mid-debounce with the button held through it
    raw[0] = 1'b1;
    step(3);
    rst = 1'b1;
    step(2);
    check_eq("s6_reset_outputs", {21'd0, press_salud, press_energia, press_hambre,
                                  press_diversion, reset_req, test_mode, btn_level}, 32'd0);
    rst = 1'b0;
    clear_obs();
    step(10);
    check_eq("s6_latency", first_salud, 7);
    raw[0] = 1'b0;
    step(12);

    // Random activity with occasional resets
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < 4; i++) if ($urandom_range(5) == 0) raw[i] = ~raw[i];
      for (int i = 4; i < 6; i++) if ($urandom_range(31) == 0) raw[i] = ~raw[i];
      rst = ($urandom_range(149) == 0);
      step(1);
    end
    rst = 1'b0;
    step(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
